// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DATA_BITS = 8;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clock_rate, input int baud_rate);
    return (clock_rate + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_done on the last of every DIV enabled cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk_tx,
  input  logic rst_clk_tx,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CNT_W = clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_done = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmitter: one character per ready/valid handshake, sent as
// start bit, 8 data bits LSB first, then STOP_BITS stop bits.
module uart_tx_ctl
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_data_vld,
  output logic       tx_ready,
  output logic       txd_tx
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_ctl: clock/baud ratio must give at least 2 clocks per bit");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx_ctl: STOP_BITS must be 1 or 2");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 accept;
  logic                 baud_en;
  logic                 bit_done;

  assign accept  = tx_ready & tx_data_vld;
  assign baud_en = (state != IDLE);

  // Cleared on accept so the start bit lasts exactly DIV cycles.
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk_tx     (clk_tx),
    .rst_clk_tx (rst_clk_tx),
    .clear      (accept),
    .enable     (baud_en),
    .bit_done   (bit_done)
  );

  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_ready <= 1'b0;
      txd_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift    <= tx_data;
            state    <= START;
            tx_ready <= 1'b0;
            txd_tx   <= 1'b0;
          end else begin
            tx_ready <= 1'b1;
            txd_tx   <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            txd_tx  <= shift[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state    <= STOP;
              stop_idx <= 1'b0;
              txd_tx   <= 1'b1;
            end else begin
              // Next bit goes to the pin in the same edge as the shift.
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              txd_tx  <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          txd_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Testbench for uart_tx_ctl: table-driven frames, corner sequences and a
// randomized run checked against a cycle-position model of the line.
module tb_uart_tx_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = 8'h00, b_data = 8'h00, c_data = 8'h00;
  logic       a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
  logic       a_ready, b_ready, c_ready;
  logic       a_txd, b_txd, c_txd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_ctl #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) u_a (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_data(a_data), .tx_data_vld(a_vld),
    .tx_ready(a_ready), .txd_tx(a_txd));

  uart_tx_ctl #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) u_b (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_data(b_data), .tx_data_vld(b_vld),
    .tx_ready(b_ready), .txd_tx(b_txd));

  uart_tx_ctl u_c (
    .clk_tx(clk), .rst_clk_tx(rst), .tx_data(c_data), .tx_data_vld(c_vld),
    .tx_ready(c_ready), .txd_tx(c_txd));

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // [0]=start, [1+i]=data bit i, [9]=stop
    bit         disturb;
  } vec_t;

  vec_t vecs[4];
  logic ln [0:259];

  task automatic check_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected line level k cycles after accept, from a fixed frame pattern.
  function automatic logic line_bit(input logic [9:0] frame, input int k, input int div);
    int slot;
    slot = (k - 1) / div;
    return (slot <= 9) ? frame[slot] : 1'b1;
  endfunction

  // Expected line level k cycles after accept, from the byte value.
  function automatic logic model_bit(input logic [7:0] b, input int k, input int div);
    int slot;
    slot = (k - 1) / div;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode_at(input int s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ln[s + 10 * (i + 1) + 5];
    return r;
  endfunction

  task automatic wait_ready_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_bit("a_ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_frame_a(input vec_t v, input string nm);
    bit ok;
    wait_ready_a(ok);
    if (!ok) return;
    a_data = v.data;
    a_vld  = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      check_bit($sformatf("%s_txd_k%0d", nm, k), a_txd, line_bit(v.frame, k, 10));
      check_bit($sformatf("%s_rdy_k%0d", nm, k), a_ready, k == 101);
      if (k == 1) a_vld = 1'b0;
      if (v.disturb) begin
        if (k == 20) a_data = 8'hFF;
        if (k == 40) begin
          a_data = 8'h12;
          a_vld  = 1'b1;
        end
        if (k == 42) a_vld = 1'b0;
      end
    end
  endtask

  initial begin
    bit         ok;
    int         s1, s2, n_acc, zeros, low_len, rdy_k, k_since, accepts;
    bit         pend;
    logic [7:0] cur, acc_data;
    logic       exp_rdy;

    vecs[0] = '{8'h41, 10'b1010000010, 1'b0};
    vecs[1] = '{8'h3C, 10'b1001111000, 1'b1};
    vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};

    // Reset behaviour
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_bit("rst_txd", a_txd, 1'b1);
      check_bit("rst_rdy", a_ready, 1'b0);
    end
    rst = 1'b0;
    #1;
    check_bit("rst_rel_rdy_before_edge", a_ready, 1'b0);
    @(negedge clk);
    check_bit("rst_first_clk_rdy", a_ready, 1'b1);
    check_bit("rst_first_clk_txd", a_txd, 1'b1);
    check_bit("rst_first_clk_rdy_b", b_ready, 1'b1);
    check_bit("rst_first_clk_rdy_c", c_ready, 1'b1);

    // Table-driven frames (vector 1 also disturbs data and valid mid-frame)
    for (int i = 0; i < 4; i++) run_frame_a(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with valid held
    wait_ready_a(ok);
    a_data = 8'h55;
    a_vld  = 1'b1;
    pend   = 1'b1;
    n_acc  = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      ln[i] = a_txd;
      if (pend) begin
        n_acc++;
        if (n_acc == 1) a_data = 8'hA3;
        else a_vld = 1'b0;
      end
      pend = a_ready && a_vld;
    end
    s1 = -1;
    s2 = -1;
    for (int i = 0; i < 260; i++) if (s1 < 0 && ln[i] == 1'b0) s1 = i;
    if (s1 >= 0) for (int i = s1 + 100; i < 260; i++) if (s2 < 0 && ln[i] == 1'b0) s2 = i;
    check_int("b2b_first_start", s1, 0);
    check_int("b2b_start_spacing", s2 - s1, 101);
    if (s1 >= 0 && s2 >= 0 && s2 + 95 < 260) begin
      check_int("b2b_byte0", int'(decode_at(s1)), 8'h55);
      check_int("b2b_byte1", int'(decode_at(s2)), 8'hA3);
      check_bit("b2b_stop0", ln[s1 + 95], 1'b1);
      check_bit("b2b_stop1", ln[s2 + 95], 1'b1);
      zeros = 0;
      for (int i = s1 + 90; i < s2; i++) if (ln[i] !== 1'b1) zeros++;
      check_int("b2b_gap_glitch", zeros, 0);
    end

    // Reset in the middle of data bit 3
    wait_ready_a(ok);
    a_data = 8'h00;
    a_vld  = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) a_vld = 1'b0;
    end
    check_bit("midrst_pre_txd", a_txd, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("midrst_async_txd", a_txd, 1'b1);
    check_bit("midrst_async_rdy", a_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_bit("midrst_rel_rdy", a_ready, 1'b1);
    run_frame_a(vecs[0], "post_rst");

    // Two stop bits
    b_data = 8'hFF;
    b_vld  = 1'b1;
    for (int k = 1; k <= 111; k++) begin
      @(negedge clk);
      check_bit($sformatf("stop2_txd_k%0d", k), b_txd, line_bit(10'b1111111110, k, 10));
      check_bit($sformatf("stop2_rdy_k%0d", k), b_ready, k == 111);
      if (k == 1) b_vld = 1'b0;
    end

    // Default parameters: 100 MHz / 115200 rounds to 868 clocks per bit
    c_data  = 8'hFF;
    c_vld   = 1'b1;
    low_len = 0;
    rdy_k   = 0;
    for (int k = 1; k <= 9000; k++) begin
      @(negedge clk);
      if (k == 1) c_vld = 1'b0;
      if (c_txd == 1'b0) low_len++;
      if (c_ready) begin
        rdy_k = k;
        break;
      end
    end
    check_int("div868_start_len", low_len, 868);
    check_int("div868_ready_cycle", rdy_k, 8681);

    // Randomized traffic against the line model
    wait_ready_a(ok);
    k_since  = 1000;
    accepts  = 0;
    pend     = 1'b0;
    cur      = 8'h00;
    acc_data = 8'h00;
    a_vld    = 1'b0;
    for (int cyc = 0; cyc < 4000 && accepts < 16; cyc++) begin
      @(negedge clk);
      if (pend) begin
        k_since = 1;
        cur     = acc_data;
        accepts++;
      end else begin
        k_since++;
      end
      exp_rdy = (k_since > 100);
      check_bit($sformatf("rnd_txd_c%0d", cyc), a_txd,
                exp_rdy ? 1'b1 : model_bit(cur, k_since, 10));
      check_bit($sformatf("rnd_rdy_c%0d", cyc), a_ready, exp_rdy);
      if (pend) begin
        if ($urandom_range(0, 1) == 1) a_data = 8'($urandom);
        else a_vld = 1'b0;
      end else if (!a_vld) begin
        a_data = 8'($urandom);
        if ($urandom_range(0, 7) == 0) a_vld = 1'b1;
      end
      pend     = exp_rdy && a_vld;
      acc_data = a_data;
    end
    a_vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
